// File: rtl/apb_master.sv
// APB bridge: latches one CPU request, decodes it to one of four 4 KiB slots and
// runs the SETUP/ACCESS handshake, flagging unmapped or timed-out transfers.
module apb_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  // The counter only needs to reach TIMEOUT_CYC-1: it reads 0 in the first ACCESS cycle.
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            hit;
  logic [1:0]      slot;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            in_access;
  logic            timeout;
  logic            done;
  logic            capture;

  // Decode from the registered address so selects stay stable for the whole transfer.
  assign hit  = (paddr_q[31:14] == BASE_ADDR[31:14]);
  assign slot = paddr_q[13:12];

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    unique case (slot)
      2'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
      2'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
      2'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
      2'd3: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
      default: ;
    endcase
  end

  assign in_access = (state_q == StAccess);
  assign timeout   = (TIMEOUT_CYC != 0) && (cnt_q == CntLast);
  assign done      = in_access && (!hit || sel_ready || timeout);

  // A slave response wins over a coincident timeout.
  assign ready = done;
  assign err   = done && (!hit || !sel_ready);
  assign rdata = (done && !err && !pwrite_q) ? sel_rdata : 32'h0;

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = in_access;
  assign PSEL0   = (state_q != StIdle) && hit && (slot == 2'd0);
  assign PSEL1   = (state_q != StIdle) && hit && (slot == 2'd1);
  assign PSEL2   = (state_q != StIdle) && hit && (slot == 2'd2);
  assign PSEL3   = (state_q != StIdle) && hit && (slot == 2'd3);

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (transfer) capture = 1'b1;
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (done) begin
          if (transfer) capture = 1'b1;
          else          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      state_d  = StSetup;
      paddr_d  = addr;
      pwdata_d = wdata;
      pwrite_d = write;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: scoreboard of expected completions plus bus-shape checks
// for write, read, back-to-back, unmapped, timeout and mid-transfer reset.
module tb_apb_master;

  localparam int Wait0 = 0;
  localparam int Wait1 = 1;
  localparam int Wait2 = 1000;
  localparam int Wait3 = 1;

  logic        PCLK, PRESETn;
  logic        transfer, write;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;
  int          acc_n;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  apb_master #(
    .BASE_ADDR  (32'h1000_0000),
    .TIMEOUT_CYC(4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL0   (PSEL0),
    .PSEL1   (PSEL1),
    .PSEL2   (PSEL2),
    .PSEL3   (PSEL3),
    .PRDATA0 (PRDATA0),
    .PRDATA1 (PRDATA1),
    .PRDATA2 (PRDATA2),
    .PRDATA3 (PRDATA3),
    .PREADY0 (PREADY0),
    .PREADY1 (PREADY1),
    .PREADY2 (PREADY2),
    .PREADY3 (PREADY3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: counts ACCESS cycles; unselected slots drive ready=1 to expose bad muxing.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_n <= 0;
    else          acc_n <= (PENABLE && !ready) ? acc_n + 1 : 0;
  end

  assign PREADY0 = PSEL0 ? (PENABLE && acc_n >= Wait0) : 1'b1;
  assign PREADY1 = PSEL1 ? (PENABLE && acc_n >= Wait1) : 1'b1;
  assign PREADY2 = PSEL2 ? (PENABLE && acc_n >= Wait2) : 1'b1;
  assign PREADY3 = PSEL3 ? (PENABLE && acc_n >= Wait3) : 1'b1;
  assign PRDATA0 = 32'h1111_0000;
  assign PRDATA1 = 32'h2222_0001;
  assign PRDATA2 = 32'h3333_0002;
  assign PRDATA3 = 32'h0000_00A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr, input bit track);
    exp_t e;
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    if (track) begin
      e.addr = a; e.wdata = d; e.write = w; e.rdata = erd; e.err = eerr;
      sb.push_back(e);
    end
  endtask

  // Waits (bounded) for ready at negedges, counts bus activity and scores the completion.
  task automatic wait_done(input string tag, input int limit, output int cyc,
                           output int s0, output int s1, output int s2, output int s3,
                           output int en);
    exp_t e;
    int   unstable;
    bit   seen;
    cyc = 0; s0 = 0; s1 = 0; s2 = 0; s3 = 0; en = 0; unstable = 0; seen = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge PCLK);
      cyc = c;
      s0 += int'(PSEL0); s1 += int'(PSEL1); s2 += int'(PSEL2); s3 += int'(PSEL3);
      en += int'(PENABLE);
      if (sb.size() > 0 && PENABLE &&
          (PADDR !== sb[0].addr || PWDATA !== sb[0].wdata || PWRITE !== sb[0].write))
        unstable++;
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, ".ready_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, ".rdata"}, rdata, e.rdata);
        chk({tag, ".err"}, 32'(err), 32'(e.err));
        chk({tag, ".bus_stable"}, 32'(unstable), 32'd0);
      end
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int act;
    act = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge PCLK);
      act += int'(ready) + int'(PENABLE) + int'(PSEL0) + int'(PSEL1) + int'(PSEL2)
             + int'(PSEL3);
    end
    chk({tag, ".idle_quiet"}, 32'(act), 32'd0);
  endtask

  initial begin
    int cyc, s0, s1, s2, s3, en;
    PRESETn = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst.paddr", PADDR, 32'h0);
    chk("rst.pwdata", PWDATA, 32'h0);
    chk("rst.ctrl", {26'd0, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3}, 32'h0);
    chk("rst.cpu", {30'd0, ready, err}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    PRESETn = 1'b1;
    idle_check("idle", 2);

    // Write to GPIO mode register, slave one ACCESS cycle late.
    issue(1'b1, 32'h1000_3000, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
    wait_done("wr_gpio", 20, cyc, s0, s1, s2, s3, en);
    chk("wr_gpio.cycles", 32'(cyc), 32'd3);
    chk("wr_gpio.psel3", 32'(s3), 32'd3);
    chk("wr_gpio.penable", 32'(en), 32'd2);
    chk("wr_gpio.other_psel", 32'(s0 + s1 + s2), 32'd0);
    chk("wr_gpio.pwdata", PWDATA, 32'h0000_00FF);
    transfer = 1'b0;
    idle_check("wr_gpio", 2);

    // Read from GPIO, then a back-to-back write to GPO held through the completion.
    issue(1'b0, 32'h1000_3004, 32'h0, 32'h0000_00A5, 1'b0, 1'b1);
    wait_done("rd_gpio", 20, cyc, s0, s1, s2, s3, en);
    chk("rd_gpio.cycles", 32'(cyc), 32'd3);
    chk("rd_gpio.pwrite", 32'(PWRITE), 32'd0);
    issue(1'b1, 32'h1000_1008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    @(negedge PCLK);
    chk("b2b.setup_sel", {28'd0, PSEL0, PSEL1, PSEL2, PSEL3}, 32'h4);
    chk("b2b.setup_en", 32'(PENABLE), 32'd0);
    chk("b2b.paddr", PADDR, 32'h1000_1008);
    wait_done("b2b_wr", 20, cyc, s0, s1, s2, s3, en);
    chk("b2b_wr.cycles", 32'(cyc), 32'd2);
    chk("b2b_wr.psel1", 32'(s1), 32'd2);
    transfer = 1'b0;
    idle_check("b2b", 2);

    // Zero-wait slave and the top word of the region.
    issue(1'b0, 32'h1000_0010, 32'h0, 32'h1111_0000, 1'b0, 1'b1);
    wait_done("rd_ram", 20, cyc, s0, s1, s2, s3, en);
    chk("rd_ram.cycles", 32'(cyc), 32'd2);
    transfer = 1'b0;
    @(negedge PCLK);
    issue(1'b0, 32'h1000_3FFC, 32'h0, 32'h0000_00A5, 1'b0, 1'b1);
    wait_done("rd_top", 20, cyc, s0, s1, s2, s3, en);
    transfer = 1'b0;
    @(negedge PCLK);

    // Unmapped addresses: no selects, error on the first ACCESS cycle.
    issue(1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_done("unmap", 20, cyc, s0, s1, s2, s3, en);
    chk("unmap.cycles", 32'(cyc), 32'd2);
    chk("unmap.psel", 32'(s0 + s1 + s2 + s3), 32'd0);
    transfer = 1'b0;
    @(negedge PCLK);
    issue(1'b1, 32'h1000_4000, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
    wait_done("unmap_edge", 20, cyc, s0, s1, s2, s3, en);
    chk("unmap_edge.psel", 32'(s0 + s1 + s2 + s3), 32'd0);
    transfer = 1'b0;
    @(negedge PCLK);

    // Timeout on GPI, which never answers.
    issue(1'b0, 32'h1000_2000, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_done("tmo", 20, cyc, s0, s1, s2, s3, en);
    chk("tmo.cycles", 32'(cyc), 32'd5);
    chk("tmo.penable", 32'(en), 32'd4);
    transfer = 1'b0;
    idle_check("tmo", 3);

    // Asynchronous reset during ACCESS aborts without a ready pulse.
    issue(1'b0, 32'h1000_3000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("arst.pre_access", {30'd0, PENABLE, PSEL3}, 32'h3);
    #1 PRESETn = 1'b0;
    #1;
    chk("arst.bus_drop", {26'd0, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3}, 32'h0);
    chk("arst.ready", 32'(ready), 32'd0);
    chk("arst.paddr", PADDR, 32'h0);
    transfer = 1'b0;
    idle_check("arst", 2);
    PRESETn = 1'b1;
    issue(1'b0, 32'h1000_3008, 32'h0, 32'h0000_00A5, 1'b0, 1'b1);
    wait_done("post_rst", 20, cyc, s0, s1, s2, s3, en);
    chk("post_rst.cycles", 32'(cyc), 32'd3);
    transfer = 1'b0;
    idle_check("post_rst", 2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB bridge between the CPU data-bus and the peripheral APB bus; sits directly upstream of the RAM and GPO/GPI/GPIO peripheral slaves.
- Latches one CPU request, decodes the address to one of four slave selects, and runs the APB SETUP/ACCESS sequence.
- Muxes the selected slave's PRDATA/PREADY back to the CPU and flags unmapped or timed-out transfers.

Parameters:
- BASE_ADDR, 32'h1000_0000, APB region base; slot n occupies BASE_ADDR + n*0x1000 (4 KiB each).
- TIMEOUT_CYC, 16, maximum ACCESS cycles without PREADY before forced error completion; 0 disables the timeout.

Ports:
- PCLK in 1: APB/system clock.
- PRESETn in 1: asynchronous, active-low reset.
- transfer in 1: CPU request strobe.
- write in 1: 1 = write, 0 = read.
- addr in 32: CPU byte address.
- wdata in 32: CPU write data.
- rdata out 32: read data to CPU.
- ready out 1: transfer-complete strobe to CPU.
- err out 1: error flag, valid with ready.
- PADDR out 32: APB address.
- PWDATA out 32: APB write data.
- PWRITE out 1: APB direction.
- PENABLE out 1: APB enable.
- PSEL0..PSEL3 out 1 each: slot selects (0 RAM, 1 GPO, 2 GPI, 3 GPIO).
- PRDATA0..PRDATA3 in 32 each: per-slot read data.
- PREADY0..PREADY3 in 1 each: per-slot ready.

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE, PADDR/PWDATA = 0, PWRITE = 0, PENABLE = 0, all PSELx = 0, timeout counter = 0.
  - Combinational outputs ready, err and rdata evaluate to 0 in IDLE.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE: on transfer=1, register addr→PADDR, wdata→PWDATA and write→PWRITE, then go to SETUP. transfer=0 stays in IDLE.
- SETUP (exactly 1 cycle): decoded PSELx=1, PENABLE=0; go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1; the counter increments each cycle.
  - Completion when the selected PREADYx=1:
    - ready=1 and err=0 combinationally that cycle.
    - rdata = selected PRDATAx on a read; rdata = 0 on a write.
  - Next state after completion:
    - If transfer=1 in the completing cycle, capture the new request and go to SETUP (back-to-back).
    - Otherwise go to IDLE, dropping PSEL/PENABLE next edge.
- Address decode: hit when addr[31:14] == BASE_ADDR[31:14]; slot = addr[13:12]. Any other address is unmapped.
- Unmapped address:
  - The FSM still passes through SETUP and ACCESS, with all PSELx=0.
  - Completes on the first ACCESS cycle with ready=1, err=1, rdata=0.
- Timeout (TIMEOUT_CYC>0): if the counter reaches TIMEOUT_CYC with no PREADY, complete that cycle with ready=1, err=1, rdata=0, then take the normal completion path. The counter clears on entering SETUP.
- PREADY and PRDATA of non-selected slots are ignored, including in IDLE and SETUP.
- transfer asserted in SETUP or in a non-completing ACCESS cycle is ignored. The CPU holds requests until it sees ready.
- PADDR/PWDATA/PWRITE are held stable from SETUP through the completing ACCESS cycle.
- Minimum latency with a registered-PREADY slave: request in cycle 0, SETUP in cycle 1, ACCESS in cycles 2–3, ready in cycle 3.
- Reset mid-transfer aborts immediately: no ready pulse, and the bus returns to reset values.

Test Plan:
- Write to GPIO mode register: addr=0x1000_3000, wdata=0xFF, slave PREADY one ACCESS cycle late → PSEL3 high for 3 cycles, PENABLE high for 2 cycles, PWDATA=0xFF, ready=1/err=0 exactly once, PSEL0–2 never high.
- Read: addr=0x1000_3004 with PRDATA3=0x0000_00A5 at completion → rdata=0xA5 in the ready cycle; PWRITE=0 throughout.
- Back-to-back: second request (write 0x1000_1008) held high during the first completion → SETUP follows with no IDLE cycle; PSEL3 falls and PSEL1 rises on the same edge.
- Unmapped: addr=0x2000_0000 → no PSELx ever high; ready=1, err=1, rdata=0 at cycle 2.
- Timeout: TIMEOUT_CYC=4, PREADY2 held at 0 → ready=1, err=1 after 4 ACCESS cycles; the FSM returns to IDLE.
- Reset: drive PRESETn low during ACCESS → PSEL/PENABLE fall without waiting for a clock edge, and no ready pulse occurs; after PRESETn rises, a new read completes normally.
